cond_logic: RTL and testbench

Conditional-execution stage of the single-cycle ARM datapath, directly downstream of the controller/decoder. It holds the architectural NZCV flag register and evaluates the instruction's condition field (Instr[31:28]) against the stored flags. It then gates the decoder's write-type controls (PCSrc, RegWrite, MemWrite, FlagWrite, byte enables) so that only executed instructions change architectural state. It also exports the stored flags for carry-consuming ALU ops and for debug.

---
 rtl/cond_logic.sv | 100 ++++++++++
 tb/tb_cond_logic.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_logic.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : cond_logic                                                   |
// | Brief    : ARM conditional-execution stage: NZCV flag register,         |
// |            condition evaluation and gating of write-type controls.      |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
module cond_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagWrite,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic [3:0] BeIn,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] be,
  output logic       CondEx,
  output logic [3:0] Flags,
  output logic       CarryIn
);

  localparam logic [3:0] c_EQ = 4'b0000;
  localparam logic [3:0] c_NE = 4'b0001;
  localparam logic [3:0] c_CS = 4'b0010;
  localparam logic [3:0] c_CC = 4'b0011;
  localparam logic [3:0] c_MI = 4'b0100;
  localparam logic [3:0] c_PL = 4'b0101;
  localparam logic [3:0] c_VS = 4'b0110;
  localparam logic [3:0] c_VC = 4'b0111;
  localparam logic [3:0] c_HI = 4'b1000;
  localparam logic [3:0] c_LS = 4'b1001;
  localparam logic [3:0] c_GE = 4'b1010;
  localparam logic [3:0] c_LT = 4'b1011;
  localparam logic [3:0] c_GT = 4'b1100;
  localparam logic [3:0] c_LE = 4'b1101;
  localparam logic [3:0] c_AL = 4'b1110;

  logic r_n, r_z, r_c, r_v;
  logic w_cond_ex;
  logic w_ge;

  // Conditions look only at the stored flags, so ALUFlags never reaches an output.
  assign w_ge = (r_n == r_v);

  always_comb begin
    w_cond_ex = 1'b0;
    case (Cond)
      c_EQ:    w_cond_ex = r_z;
      c_NE:    w_cond_ex = ~r_z;
      c_CS:    w_cond_ex = r_c;
      c_CC:    w_cond_ex = ~r_c;
      c_MI:    w_cond_ex = r_n;
      c_PL:    w_cond_ex = ~r_n;
      c_VS:    w_cond_ex = r_v;
      c_VC:    w_cond_ex = ~r_v;
      c_HI:    w_cond_ex = r_c & ~r_z;
      c_LS:    w_cond_ex = ~r_c | r_z;
      c_GE:    w_cond_ex = w_ge;
      c_LT:    w_cond_ex = ~w_ge;
      c_GT:    w_cond_ex = ~r_z & w_ge;
      c_LE:    w_cond_ex = r_z | ~w_ge;
      c_AL:    w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // NZ and CV pairs update independently so S-suffixed logical ops keep C and V.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n <= 1'b0;
      r_z <= 1'b0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else begin
      if (FlagWrite[1] & w_cond_ex) begin
        r_n <= ALUFlags[3];
        r_z <= ALUFlags[2];
      end
      if (FlagWrite[0] & w_cond_ex) begin
        r_c <= ALUFlags[1];
        r_v <= ALUFlags[0];
      end
    end
  end

  assign CondEx   = w_cond_ex;
  assign PCSrc    = PCS  & w_cond_ex;
  assign RegWrite = RegW & w_cond_ex;
  assign MemWrite = MemW & w_cond_ex;
  assign be       = (MemW & w_cond_ex) ? BeIn : 4'b0000;
  assign Flags    = {r_n, r_z, r_c, r_v};
  assign CarryIn  = r_c;

endmodule
`default_nettype wire

// File: tb/tb_cond_logic.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_cond_logic                                                |
// | Brief    : Directed self-checking bench for cond_logic.                 |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
module tb_cond_logic;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagWrite;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic [3:0] BeIn;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] be;
  logic       CondEx;
  logic [3:0] Flags;
  logic       CarryIn;

  int n_cmp;
  int n_err;

  cond_logic u_dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagWrite(FlagWrite),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .BeIn     (BeIn),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .be       (be),
    .CondEx   (CondEx),
    .Flags    (Flags),
    .CarryIn  (CarryIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition table written straight from the ISA encoding.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (c)
      4'd0:    return fz;
      4'd1:    return !fz;
      4'd2:    return fc;
      4'd3:    return !fc;
      4'd4:    return fn;
      4'd5:    return !fn;
      4'd6:    return fv;
      4'd7:    return !fv;
      4'd8:    return fc && !fz;
      4'd9:    return !fc || fz;
      4'd10:   return fn == fv;
      4'd11:   return fn != fv;
      4'd12:   return !fz && (fn == fv);
      4'd13:   return fz || (fn != fv);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_flags(input logic [3:0] f);
    @(negedge clk);
    Cond      = 4'b1110;
    FlagWrite = 2'b11;
    ALUFlags  = f;
    @(posedge clk);
    #1;
    FlagWrite = 2'b00;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if (Flags !== 4'b0000 || CarryIn !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: Flags=%b CarryIn=%b, expected 0000/0", Flags, CarryIn);
    end
    n_cmp++;
    if (CondEx !== 1'b1 || RegWrite !== 1'b1 || MemWrite !== 1'b1 || be !== 4'b1111) begin
      n_err++;
      $display("FAIL reset_al: CondEx=%b RegWrite=%b MemWrite=%b be=%b, expected 1/1/1/1111",
               CondEx, RegWrite, MemWrite, be);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (Flags !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_hold: Flags=%b, expected 0000", Flags);
    end
    Cond = 4'b0000;
    #1;
    n_cmp++;
    if (CondEx !== 1'b0 || be !== 4'b0000 || RegWrite !== 1'b0) begin
      n_err++;
      $display("FAIL reset_eq: CondEx=%b be=%b RegWrite=%b, expected 0/0000/0", CondEx, be, RegWrite);
    end
  endtask

  task automatic test_flag_write;
    @(negedge clk);
    reset = 1'b1;
    RegW = 1'b0; MemW = 1'b0; BeIn = 4'b0000;
    Cond = 4'b0000;
    ALUFlags = 4'b0100;
    #1;
    // ALUFlags already shows Z but EQ must still fail before the edge.
    n_cmp++;
    if (CondEx !== 1'b0) begin
      n_err++;
      $display("FAIL latency_before: CondEx=%b, expected 0", CondEx);
    end
    Cond = 4'b1110;
    FlagWrite = 2'b11;
    @(posedge clk);
    #1;
    n_cmp++;
    if (Flags !== 4'b0100) begin
      n_err++;
      $display("FAIL flag_write: Flags=%b, expected 0100", Flags);
    end
    FlagWrite = 2'b00;
    Cond = 4'b0000;
    #1;
    n_cmp++;
    if (CondEx !== 1'b1) begin
      n_err++;
      $display("FAIL latency_after: CondEx=%b, expected 1", CondEx);
    end
  endtask

  task automatic test_split_write;
    set_flags(4'b1111);
    @(negedge clk);
    Cond = 4'b1110;
    FlagWrite = 2'b10;
    ALUFlags = 4'b0000;
    @(posedge clk);
    #1;
    FlagWrite = 2'b00;
    n_cmp++;
    if (Flags !== 4'b0011 || CarryIn !== 1'b1) begin
      n_err++;
      $display("FAIL split_nz: Flags=%b CarryIn=%b, expected 0011/1", Flags, CarryIn);
    end
    @(negedge clk);
    FlagWrite = 2'b01;
    ALUFlags = 4'b1100;
    @(posedge clk);
    #1;
    FlagWrite = 2'b00;
    n_cmp++;
    if (Flags !== 4'b0000 || CarryIn !== 1'b0) begin
      n_err++;
      $display("FAIL split_cv: Flags=%b CarryIn=%b, expected 0000/0", Flags, CarryIn);
    end
  endtask

  task automatic test_blocked;
    set_flags(4'b0000);
    @(negedge clk);
    Cond = 4'b0000;
    FlagWrite = 2'b11;
    ALUFlags = 4'b1111;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; BeIn = 4'b0011;
    #1;
    n_cmp++;
    if (PCSrc !== 1'b0 || RegWrite !== 1'b0 || MemWrite !== 1'b0 || be !== 4'b0000) begin
      n_err++;
      $display("FAIL blocked_ctrl: PCSrc=%b RegWrite=%b MemWrite=%b be=%b, expected 0/0/0/0000",
               PCSrc, RegWrite, MemWrite, be);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (Flags !== 4'b0000) begin
      n_err++;
      $display("FAIL blocked_flags: Flags=%b, expected 0000", Flags);
    end
    // Same controls with AL pass straight through.
    Cond = 4'b1110;
    FlagWrite = 2'b00;
    #1;
    n_cmp++;
    if (PCSrc !== 1'b1 || RegWrite !== 1'b1 || MemWrite !== 1'b1 || be !== 4'b0011) begin
      n_err++;
      $display("FAIL pass_ctrl: PCSrc=%b RegWrite=%b MemWrite=%b be=%b, expected 1/1/1/0011",
               PCSrc, RegWrite, MemWrite, be);
    end
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; BeIn = 4'b0000;
  endtask

  task automatic test_cond_sweep;
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #1;
        n_cmp++;
        if (CondEx !== cond_model(4'(c), 4'(f))) begin
          n_err++;
          $display("FAIL sweep flags=%b cond=%b: CondEx=%b, expected %b",
                   4'(f), 4'(c), CondEx, cond_model(4'(c), 4'(f)));
        end
      end
    end
  endtask

  task automatic test_spot;
    set_flags(4'b1001);
    Cond = 4'b1010; #1;
    n_cmp++;
    if (CondEx !== 1'b1) begin n_err++; $display("FAIL spot_ge: CondEx=%b, expected 1", CondEx); end
    Cond = 4'b1100; #1;
    n_cmp++;
    if (CondEx !== 1'b1) begin n_err++; $display("FAIL spot_gt: CondEx=%b, expected 1", CondEx); end
    Cond = 4'b1011; #1;
    n_cmp++;
    if (CondEx !== 1'b0) begin n_err++; $display("FAIL spot_lt: CondEx=%b, expected 0", CondEx); end
    set_flags(4'b0110);
    Cond = 4'b1000; #1;
    n_cmp++;
    if (CondEx !== 1'b0) begin n_err++; $display("FAIL spot_hi: CondEx=%b, expected 0", CondEx); end
    Cond = 4'b1001; #1;
    n_cmp++;
    if (CondEx !== 1'b1) begin n_err++; $display("FAIL spot_ls: CondEx=%b, expected 1", CondEx); end
    n_cmp++;
    if (CarryIn !== 1'b1) begin n_err++; $display("FAIL spot_carry: CarryIn=%b, expected 1", CarryIn); end
  endtask

  task automatic test_async_reset;
    set_flags(4'b1010);
    @(negedge clk);
    Cond = 4'b1110;
    FlagWrite = 2'b11;
    ALUFlags = 4'b0101;
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (Flags !== 4'b0000 || CarryIn !== 1'b0) begin
      n_err++;
      $display("FAIL async_clear: Flags=%b CarryIn=%b, expected 0000/0", Flags, CarryIn);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (Flags !== 4'b0000) begin
      n_err++;
      $display("FAIL async_lost_write: Flags=%b, expected 0000", Flags);
    end
    @(negedge clk);
    reset = 1'b1;
    ALUFlags = 4'b0110;
    @(posedge clk);
    #1;
    FlagWrite = 2'b00;
    n_cmp++;
    if (Flags !== 4'b0110 || CarryIn !== 1'b1) begin
      n_err++;
      $display("FAIL async_release: Flags=%b CarryIn=%b, expected 0110/1", Flags, CarryIn);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    Cond = 4'b1110;
    ALUFlags = 4'b0000;
    FlagWrite = 2'b00;
    PCS = 1'b0;
    RegW = 1'b1;
    MemW = 1'b1;
    BeIn = 4'b1111;
    test_reset;
    test_flag_write;
    test_split_write;
    test_blocked;
    test_cond_sweep;
    test_spot;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
